// File: rtl/ram_tap_delay_line.sv
// ram_tap_delay_line
// ------------------
// Multi-lane, RAM-based delay line with a variable length, used in the Kyber
// datapath. One circular buffer holds all lanes side by side. Every lane
// shares one write/read pointer, one fill counter and one valid flag. The
// delay is counted in accepted samples, not in clock cycles.
//
// Handshake: there is no back-pressure. A sample is accepted on every rising
// edge where in_valid=1. out_valid=1 marks the cycle after an accept whose
// read returned a sample that is exactly len_q accepts old. dout holds its
// value in every cycle that has no accept.
//
// Ports:
//   clk        rising-edge clock
//   Reset      synchronous, active-high reset (RAM contents are kept)
//   len        requested delay length in accepted samples (0 -> 1, >WDEPTH -> WDEPTH)
//   in_valid   din is accepted this cycle
//   din        input samples, lane k at [k*DSIZE +: DSIZE]
//   dout       delayed samples, same lane layout as din
//   out_valid  dout holds a valid delayed sample
//   primed     the buffer holds len_q samples
//   fill_level current fill count
//
// Optional build macro DLY_OUT_REG_EN adds one output register stage on
// dout/out_valid. This raises the accept-to-output latency from 1 to 2
// cycles. primed and fill_level are not delayed by that stage.

module ram_tap_delay_line #(
  parameter int DSIZE  = 6,
  parameter int NCH    = 1,
  parameter int WDEPTH = 10,
  parameter int ASIZE  = $clog2(WDEPTH + 1),
  parameter int PSIZE  = (WDEPTH > 1) ? $clog2(WDEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [ASIZE-1:0]       len,
  input  logic                   in_valid,
  input  logic [DSIZE*NCH-1:0]   din,
  output logic [DSIZE*NCH-1:0]   dout,
  output logic                   out_valid,
  output logic                   primed,
  output logic [ASIZE-1:0]       fill_level
);

  localparam int DW = DSIZE * NCH;
  localparam logic [ASIZE-1:0] LEN_MAX = ASIZE'(WDEPTH);
  localparam logic [ASIZE-1:0] LEN_ONE = ASIZE'(1);

  logic [DW-1:0]    mem [WDEPTH];
  logic [PSIZE-1:0] wp;
  logic [ASIZE-1:0] fill;
  logic [ASIZE-1:0] len_q;
  logic [ASIZE-1:0] len_eff;
  logic             len_chg;
  logic             wp_last;
  logic             full;
  logic             wr_en;
  logic [PSIZE-1:0] wr_addr;
  logic [DW-1:0]    dout_c;
  logic             out_valid_c;

  // Clamp the requested length into the legal range 1..WDEPTH.
  always_comb begin
    len_eff = len;
    if (len == '0) begin
      len_eff = LEN_ONE;
    end else if (len > LEN_MAX) begin
      len_eff = LEN_MAX;
    end
  end

  assign len_chg = (len_eff != len_q);
  // The pointer wraps at the programmed length. Entries at or above len_q
  // are never used.
  assign wp_last = (ASIZE'(wp) == (len_q - LEN_ONE));
  assign full    = (fill == len_q);

  // A length change restarts the buffer at entry 0. A sample accepted in
  // that same cycle becomes the first entry of the new window.
  assign wr_en   = in_valid & ~Reset;
  assign wr_addr = len_chg ? '0 : wp;

  // RAM array with no reset. Stale contents are masked by the fill tracking.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  // Pointer, fill and core output registers. The read of mem[wp] returns
  // the old contents, which were written len_q accepts earlier.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wp          <= '0;
      fill        <= '0;
      len_q       <= len_eff;
      dout_c      <= '0;
      out_valid_c <= 1'b0;
    end else if (len_chg) begin
      len_q       <= len_eff;
      out_valid_c <= 1'b0;
      if (in_valid) begin
        wp   <= (len_eff == LEN_ONE) ? '0 : PSIZE'(1);
        fill <= LEN_ONE;
      end else begin
        wp   <= '0;
        fill <= '0;
      end
    end else if (in_valid) begin
      dout_c      <= mem[wp];
      wp          <= wp_last ? '0 : wp + PSIZE'(1);
      out_valid_c <= full;
      fill        <= full ? fill : fill + LEN_ONE;
    end else begin
      out_valid_c <= 1'b0;
    end
  end

`ifdef DLY_OUT_REG_EN
  // Free-running retiming stage between the RAM read and the fabric. It
  // captures every cycle and is not gated by in_valid.
  always_ff @(posedge clk) begin
    if (Reset) begin
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      dout      <= dout_c;
      out_valid <= out_valid_c;
    end
  end
`else
  assign dout      = dout_c;
  assign out_valid = out_valid_c;
`endif

  assign primed     = full;
  assign fill_level = fill;

endmodule

// File: tb/tb_ram_tap_delay_line.sv
// Directed testbench for ram_tap_delay_line (NCH=1, DSIZE=6, WDEPTH=10).
// The expected values are computed by hand for each step. In the
// DLY_OUT_REG_EN build, dout/out_valid are checked one cycle later than in
// the default build. primed and fill_level are checked with the same timing
// in both builds.

module tb_ram_tap_delay_line;

  localparam int DSIZE  = 6;
  localparam int NCH    = 1;
  localparam int WDEPTH = 10;
  localparam int ASIZE  = 4;
  localparam int DW     = DSIZE * NCH;

`ifdef DLY_OUT_REG_EN
  localparam bit OREG = 1'b1;
`else
  localparam bit OREG = 1'b0;
`endif

  logic             clk;
  logic             Reset;
  logic [ASIZE-1:0] len;
  logic             in_valid;
  logic [DW-1:0]    din;
  logic [DW-1:0]    dout;
  logic             out_valid;
  logic             primed;
  logic [ASIZE-1:0] fill_level;

  int total;
  int bad;

  // Expected core (pre-stage) outputs after the most recent edge.
  logic [DW-1:0] cd;
  bit            cv;
  bit            ck;

  ram_tap_delay_line #(
    .DSIZE (DSIZE),
    .NCH   (NCH),
    .WDEPTH(WDEPTH)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .len       (len),
    .in_valid  (in_valid),
    .din       (din),
    .dout      (dout),
    .out_valid (out_valid),
    .primed    (primed),
    .fill_level(fill_level)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // d/v/k describe the core output after this edge. k=0 means dout is
  // don't-care, because the slot holds stale or uninitialised RAM data.
  task automatic expect_out(input logic [DW-1:0] d, input bit v, input bit k);
    logic [DW-1:0] ed;
    bit ev;
    bit ek;
    if (OREG) begin
      ed = cd; ev = cv; ek = ck;
    end else begin
      ed = d; ev = v; ek = k;
    end
    cd = d; cv = v; ck = k;
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ek) chk("dout", 32'(dout), 32'(ed));
  endtask

  // Apply one cycle of stimulus, then check the outputs 1 time unit after the edge.
  task automatic acc(input bit iv, input logic [DW-1:0] dv,
                     input logic [DW-1:0] ed, input bit ev, input bit ek,
                     input int ef, input bit ep);
    in_valid = iv;
    din      = dv;
    @(posedge clk);
    #1;
    expect_out(ed, ev, ek);
    chk("fill_level", 32'(fill_level), 32'(ef));
    chk("primed", 32'(primed), 32'(ep));
  endtask

  task automatic do_reset(input logic [ASIZE-1:0] l, input bit iv);
    Reset    = 1'b1;
    len      = l;
    in_valid = iv;
    din      = 6'd33;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);
    cd = '0; cv = 1'b0; ck = 1'b1;
  endtask

  function automatic int min4(input int x);
    return (x > 4) ? 4 : x;
  endfunction

  initial begin
    total = 0; bad = 0;
    Reset = 1'b1; len = 4'd4; in_valid = 1'b0; din = '0;
    cd = '0; cv = 1'b0; ck = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Scenario 1: len=4 with continuous accepts, then one idle cycle.
    do_reset(4'd4, 1'b0);
    for (int n = 0; n < 12; n++)
      acc(1'b1, 6'(n), 6'(n - 4), n >= 4, n >= 4, min4(n + 1), n >= 3);
    acc(1'b0, 6'd0, cd, 1'b0, ck, 4, 1'b1);

    // Scenario 2: len=4 with in_valid alternating 1,0. dout holds in gap cycles.
    do_reset(4'd4, 1'b0);
    for (int n = 0; n < 12; n++) begin
      acc(1'b1, 6'(n), 6'(n - 4), n >= 4, n >= 4, min4(n + 1), n >= 3);
      acc(1'b0, 6'd0, cd, 1'b0, ck, min4(n + 1), n >= 3);
    end

    // Scenario 3: change to len=15 mid-stream, which clamps to 10.
    len = 4'd15;
    acc(1'b1, 6'd40, cd, 1'b0, ck, 1, 1'b0);
    for (int k = 1; k < 10; k++)
      acc(1'b1, 6'(40 + k), 6'd0, 1'b0, 1'b0, k + 1, k == 9);
    for (int k = 10; k < 14; k++)
      acc(1'b1, 6'(40 + k), 6'(30 + k), 1'b1, 1'b1, 10, 1'b1);

    // Scenario 4: len=0 behaves as len=1.
    do_reset(4'd0, 1'b0);
    for (int n = 0; n < 6; n++)
      acc(1'b1, 6'(5 + n), 6'(4 + n), n >= 1, n >= 1, 1, 1'b1);

    // Scenario 5: reset pulsed mid-stream while in_valid=1. Stale RAM data
    // must not appear with out_valid high.
    do_reset(4'd4, 1'b0);
    for (int n = 0; n < 6; n++)
      acc(1'b1, 6'(n), 6'(n - 4), n >= 4, n >= 4, min4(n + 1), n >= 3);
    do_reset(4'd4, 1'b1);
    for (int n = 0; n < 7; n++)
      acc(1'b1, 6'(60 + n), 6'(56 + n), n >= 4, n >= 4, min4(n + 1), n >= 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
